// File: rtl/ctrl_bubble_pipe.sv
// Control-bundle pipeline with per-stage stall/flush, bubble insertion and a
// saturating count of bubbles reaching the last stage.
module ctrl_bubble_pipe #(
  parameter int unsigned      WIDTH = 20,
  parameter int unsigned      DEPTH = 3,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_ctrl,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH*WIDTH-1:0] out_ctrl,
  output logic [DEPTH-1:0]       out_valid,
  output logic [15:0]            bubble_cnt
);

  logic [DEPTH-1:0] hold;
  logic [WIDTH-1:0] ctrl_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic             last_valid_d;
  logic [15:0]      bubble_q, bubble_d;

  // A stall anywhere downstream freezes this stage and everything upstream of it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = |(stall >> i);
    end
  end

  assign in_ready = ~hold[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] ctrl_d;
    logic             valid_d;

    if (g == 0) begin : g_head
      always_comb begin
        ctrl_d  = ctrl_q[0];
        valid_d = valid_q[0];
        if (flush[0]) begin
          ctrl_d  = NOP;
          valid_d = 1'b0;
        end else if (!hold[0]) begin
          ctrl_d  = in_valid ? in_ctrl : NOP;
          valid_d = in_valid;
        end
      end
    end else begin : g_body
      always_comb begin
        ctrl_d  = ctrl_q[g];
        valid_d = valid_q[g];
        if (flush[g]) begin
          ctrl_d  = NOP;
          valid_d = 1'b0;
        end else if (!hold[g]) begin
          // Upstream frozen while this stage drains: insert a bubble.
          if (hold[g-1]) begin
            ctrl_d  = NOP;
            valid_d = 1'b0;
          end else begin
            ctrl_d  = ctrl_q[g-1];
            valid_d = valid_q[g-1];
          end
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_q[g]  <= NOP;
        valid_q[g] <= 1'b0;
      end else begin
        ctrl_q[g]  <= ctrl_d;
        valid_q[g] <= valid_d;
      end
    end

    // Invalid stages always hold NOP, so the stored value is safe to expose.
    assign out_ctrl[g*WIDTH +: WIDTH] = ctrl_q[g];
    assign out_valid[g]               = valid_q[g];

    if (g == DEPTH - 1) begin : g_last
      assign last_valid_d = valid_d;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!hold[DEPTH-1] && !last_valid_d && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= 16'd0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Directed bench for ctrl_bubble_pipe: a DEPTH=3 instance with a scoreboard on
// the last stage, plus a DEPTH=1 instance with a non-zero NOP.
module tb_ctrl_bubble_pipe;
  localparam int W = 20;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_ctrl;
  logic           in_valid;
  logic           in_ready;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic [D*W-1:0] out_ctrl;
  logic [D-1:0]   out_valid;
  logic [15:0]    bubble_cnt;

  logic [7:0]  in_ctrl1;
  logic        in_valid1;
  logic        in_ready1;
  logic [0:0]  stall1;
  logic [0:0]  flush1;
  logic [7:0]  out_ctrl1;
  logic [0:0]  out_valid1;
  logic [15:0] bubble_cnt1;

  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] bub_before;

  ctrl_bubble_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_ctrl    (in_ctrl),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .out_ctrl   (out_ctrl),
    .out_valid  (out_valid),
    .bubble_cnt (bubble_cnt)
  );

  ctrl_bubble_pipe #(.WIDTH(8), .DEPTH(1), .NOP(8'h5A)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_ctrl    (in_ctrl1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .stall      (stall1),
    .flush      (flush1),
    .out_ctrl   (out_ctrl1),
    .out_valid  (out_valid1),
    .bubble_cnt (bubble_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock for the DEPTH=3 instance: record accepted input, then score stage 2.
  task automatic tick();
    #1;
    if (in_valid && in_ready) exp_q.push_back(in_ctrl);
    @(posedge clk);
    #1;
    if (out_valid[D-1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed %0h expected no valid output", out_ctrl[2*W +: W]);
      end else begin
        check("sb_data", 64'(out_ctrl[2*W +: W]), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_ctrl   = '0;
    in_valid  = 1'b0;
    stall     = '0;
    flush     = '0;
    in_ctrl1  = '0;
    in_valid1 = 1'b0;
    stall1    = '0;
    flush1    = '0;

    #3;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_ctrl", 64'(out_ctrl), 64'h0);
    check("rst_bubble", 64'(bubble_cnt), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);
    check("rst_ctrl1_nop", 64'(out_ctrl1), 64'h5A);
    check("rst_valid1", 64'(out_valid1), 64'h0);
    stall = 3'b100;
    #1;
    check("rst_ready_stall", 64'(in_ready), 64'h0);
    stall = '0;
    @(negedge clk);
    reset = 1'b0;

    // Three back-to-back bundles.
    in_valid = 1'b1;
    in_ctrl  = 20'hA1111;
    tick();
    check("s0_a", 64'(out_ctrl[0 +: W]), 64'hA1111);
    check("valid_1", 64'(out_valid), 64'h1);
    in_ctrl = 20'hB2222;
    tick();
    check("s1_a", 64'(out_ctrl[W +: W]), 64'hA1111);
    check("valid_2", 64'(out_valid), 64'h3);
    in_ctrl = 20'hC3333;
    tick();
    check("valid_full", 64'(out_valid), 64'h7);
    check("bubble_stream", 64'(bubble_cnt), 64'd2);

    // Middle stall: upstream holds, last stage takes a bubble.
    stall   = 3'b010;
    in_ctrl = 20'hD4444;
    #1;
    check("ready_stall_mid", 64'(in_ready), 64'h0);
    tick();
    check("valid_stall_mid", 64'(out_valid), 64'h3);
    check("s2_bubble_nop", 64'(out_ctrl[2*W +: W]), 64'h0);
    check("s0_hold_c", 64'(out_ctrl[0 +: W]), 64'hC3333);
    check("s1_hold_b", 64'(out_ctrl[W +: W]), 64'hB2222);
    check("bubble_stall", 64'(bubble_cnt), 64'd3);
    stall = '0;
    tick();
    check("valid_resume", 64'(out_valid), 64'h7);
    check("bubble_resume", 64'(bubble_cnt), 64'd3);

    // Flush of stages 0/1 while stage 0 is also stalled.
    flush   = 3'b011;
    stall   = 3'b001;
    in_ctrl = 20'hE5555;
    #1;
    check("ready_flush_stall", 64'(in_ready), 64'h0);
    tick();
    check("valid_flush", 64'(out_valid), 64'h4);
    check("ctrl_flush_nop", 64'(out_ctrl[0 +: 2*W]), 64'h0);
    check("bubble_flush", 64'(bubble_cnt), 64'd3);
    exp_q.delete();
    flush    = '0;
    stall    = '0;
    in_valid = 1'b0;
    tick();
    check("valid_drain", 64'(out_valid), 64'h0);
    check("ctrl_drain_nop", 64'(out_ctrl), 64'h0);
    check("bubble_drain", 64'(bubble_cnt), 64'd4);

    // Refill, then reset between edges.
    in_valid = 1'b1;
    in_ctrl  = 20'hF6666;
    tick();
    in_ctrl = 20'h17777;
    tick();
    in_ctrl = 20'h28888;
    tick();
    check("valid_refill", 64'(out_valid), 64'h7);
    check("bubble_refill", 64'(bubble_cnt), 64'd6);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_ctrl", 64'(out_ctrl), 64'h0);
    check("midrst_bubble", 64'(bubble_cnt), 64'h0);
    reset = 1'b0;
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    check("post_rst_bubble", 64'(bubble_cnt), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'h0);

    // Saturation.
    repeat (65533) tick();
    check("bubble_fffe", 64'(bubble_cnt), 64'hFFFE);
    tick();
    check("bubble_ffff", 64'(bubble_cnt), 64'hFFFF);
    repeat (4460) tick();
    check("bubble_sat_hold", 64'(bubble_cnt), 64'hFFFF);

    // DEPTH=1 instance.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("d1_rst_bubble", 64'(bubble_cnt1), 64'h0);
    check("d1_rst_ctrl", 64'(out_ctrl1), 64'h5A);
    reset = 1'b0;
    tick1();
    tick1();
    check("d1_bubble_idle", 64'(bubble_cnt1), 64'd2);
    in_valid1 = 1'b1;
    in_ctrl1  = 8'h11;
    #1;
    check("d1_ready", 64'(in_ready1), 64'h1);
    tick1();
    check("d1_ctrl_load", 64'(out_ctrl1), 64'h11);
    check("d1_valid_load", 64'(out_valid1), 64'h1);
    check("d1_bubble_valid", 64'(bubble_cnt1), 64'd2);
    stall1   = 1'b1;
    flush1   = 1'b1;
    in_ctrl1 = 8'h22;
    #1;
    check("d1_ready_stall", 64'(in_ready1), 64'h0);
    tick1();
    check("d1_ctrl_flush", 64'(out_ctrl1), 64'h5A);
    check("d1_valid_flush", 64'(out_valid1), 64'h0);
    flush1 = 1'b0;
    tick1();
    check("d1_ctrl_hold", 64'(out_ctrl1), 64'h5A);
    check("d1_ready_hold", 64'(in_ready1), 64'h0);
    stall1 = 1'b0;
    #1;
    check("d1_ready_release", 64'(in_ready1), 64'h1);
    tick1();
    check("d1_ctrl_kept", 64'(out_ctrl1), 64'h22);
    check("d1_valid_kept", 64'(out_valid1), 64'h1);
    bub_before = bubble_cnt1 + 16'd1;
    in_valid1  = 1'b0;
    tick1();
    check("d1_ctrl_idle_nop", 64'(out_ctrl1), 64'h5A);
    check("d1_bubble_inc", 64'(bubble_cnt1), 64'(bub_before));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_bubble_pipe.md
CTRL_BUBBLE_PIPE -- requirements
Module: ctrl_bubble_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, the control-bundle width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 3, the number of pipeline stages, legal range 1..4.
REQ-003 The block SHALL have parameter NOP, default all-zero WIDTH bits, the bubble value loaded into a squashed or starved stage.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port in_ctrl, input, WIDTH bits, the decoded control bundle offered to stage 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_ctrl holds a real instruction.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning stage 0 accepts input this cycle.
REQ-009 The block SHALL have port stall, input, DEPTH bits; stall[i] requests stage i to hold.
REQ-010 The block SHALL have port flush, input, DEPTH bits; flush[i] requests that stage i be squashed.
REQ-011 The block SHALL have port out_ctrl, output, DEPTH*WIDTH bits; stage i occupies bits [i*WIDTH +: WIDTH].
REQ-012 The block SHALL have port out_valid, output, DEPTH bits, the valid flag of each stage.
REQ-013 The block SHALL have port bubble_cnt, output, 16 bits, a saturating count of bubbles that have entered the last stage.

Function
REQ-014 Stage i SHALL hold, written hold[i], when any stall[j] with j >= i is 1, so that a downstream stall freezes every upstream stage.
REQ-015 The block SHALL drive in_ready = ~hold[0], combinationally.
REQ-016 On a clock edge with flush[i]=1, stage i SHALL load NOP with valid 0; flush SHALL take priority over hold and over advance.
REQ-017 On a clock edge with flush[i]=0 and hold[i]=1, stage i SHALL keep its current contents and valid flag.
REQ-018 On a clock edge with flush[i]=0, hold[i]=0, i>0 and hold[i-1]=1, stage i SHALL load NOP with valid 0, which inserts a bubble.
REQ-019 On a clock edge with flush[i]=0, hold[i]=0, i>0 and hold[i-1]=0, stage i SHALL load the contents and valid flag of stage i-1.
REQ-020 On a clock edge with flush[0]=0 and hold[0]=0, stage 0 SHALL load in_ctrl with valid=in_valid when in_valid=1, and NOP with valid 0 when in_valid=0.
REQ-021 Whenever out_valid[i]=0, out_ctrl for stage i SHALL equal NOP, so that downstream logic never sees stale control values.
REQ-022 Latency from acceptance into stage 0 to arrival at stage DEPTH-1 SHALL be DEPTH-1 clock edges when no stage holds.
REQ-023 bubble_cnt SHALL increment by 1 on each edge at which stage DEPTH-1 loads valid 0 and is not holding.
REQ-024 bubble_cnt SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-025 When DEPTH=1, the block SHALL behave as a single register with stall and flush, and bubble_cnt SHALL count the edges at which the stage loads invalid.
REQ-026 When flush[i] and stall[i] are asserted together, flush SHALL win, and upstream stages SHALL still hold per REQ-014.

Reset
REQ-027 While reset=1, asynchronously and independent of clk, every stage SHALL hold NOP with valid 0 and bubble_cnt SHALL be 0.
REQ-028 While reset=1, in_ready SHALL follow REQ-015, and the first rising edge after reset deasserts SHALL perform normal operation.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight stages immediately, with no partial update at the next edge.

Verification
REQ-030 Scenario: WIDTH=20, DEPTH=3, three valid bundles A, B, C on consecutive cycles with no stall -> A appears at stage 2 two edges after acceptance, followed by B then C; bubble_cnt stays unchanged while valid bundles arrive.
REQ-031 Scenario: stall=3'b010 for one cycle with the pipe full of A, B, C -> stages 0 and 1 hold, stage 2 loads NOP with valid 0, in_ready=0 for that cycle, and bubble_cnt increases by 1.
REQ-032 Scenario: flush=3'b011 together with stall=3'b001 -> stages 0 and 1 become NOP with valid 0 on the next edge, and stage 2 advances normally.
REQ-033 Scenario: in_valid=0 for 70000 cycles -> bubble_cnt reaches 16'hFFFF and remains there.
REQ-034 Scenario: reset pulsed between clock edges while the pipe is full -> all out_valid go to 0, out_ctrl equals NOP, and bubble_cnt=0 before the next edge.
REQ-035 Scenario: DEPTH=1 with a stall plus a flush on the same edge -> the stage is flushed to NOP with valid 0, in_ready=0 during the stall, and the stalled input is not lost.
